sram_bus_arbiter: RTL

//  Shares one SRAM-like memory port between the fetch side (inst) and the MEM-stage side (data).

---
 rtl/sram_bus_arbiter_pkg.sv | 29 ++
 rtl/sram_bus_arbiter_id_fifo.sv | 55 +++++
 rtl/sram_bus_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
// Shared SRAM-like field widths, side IDs and request bundle for the inst/data memory arbiter.
package sram_bus_arbiter_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int SIZE_W = 2;

  localparam logic ARB_ID_INST = 1'b0;
  localparam logic ARB_ID_DATA = 1'b1;

  typedef enum logic [SIZE_W-1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_t;

  typedef enum logic {
    LK_FREE = 1'b0,
    LK_HELD = 1'b1
  } lock_st_t;

  typedef struct packed {
    logic              wr;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] addr;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } sram_req_t;
endpackage

// File: rtl/sram_bus_arbiter_id_fifo.sv
// In-order record of which side issued each accepted-but-unanswered transaction.
module arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_push,
  input  logic          i_id,
  input  logic          i_pop,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_head,
  output logic [CW-1:0] o_count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] r_mem;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_id;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like port between inst and data sides; responses return in issue order.
// state   | meaning
// LK_FREE | grant recomputed every cycle from requests and starvation count
// LK_HELD | downstream saw a request without addr_ok; grant pinned to r_lock_id
module sram_bus_arbiter
  import sram_bus_arbiter_pkg::*;
#(
  parameter int MAX_OUTST    = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = $clog2(MAX_OUTST + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_req,
  input  logic              i_wr,
  input  logic [SIZE_W-1:0] i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [SIZE_W-1:0] d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [STRB_W-1:0] d_wstrb,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [SIZE_W-1:0] m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [STRB_W-1:0] m_wstrb,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata,
  output logic [CNT_W-1:0]  outst_cnt,
  output logic              proto_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  lock_st_t  r_lock_st, w_lock_nxt;
  logic      r_lock_id, w_lock_id_nxt;
  logic [SW-1:0] r_starve_cnt;
  logic      r_proto_err;
  logic      w_grant_vld, w_grant_id, w_hs;
  logic      w_full, w_empty, w_head, w_pop;
  sram_req_t w_i_fields, w_d_fields, w_sel;

  assign w_i_fields = '{wr: i_wr, size: i_size, addr: i_addr, wstrb: i_wstrb, wdata: i_wdata};
  assign w_d_fields = '{wr: d_wr, size: d_size, addr: d_addr, wstrb: d_wstrb, wdata: d_wdata};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_lock_st <= LK_FREE;
      r_lock_id <= ARB_ID_INST;
    end else begin
      r_lock_st <= w_lock_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  always_comb begin
    w_lock_nxt    = r_lock_st;
    w_lock_id_nxt = r_lock_id;
    if (m_req && !m_addr_ok) begin
      w_lock_nxt    = LK_HELD;
      w_lock_id_nxt = w_grant_id;
    end else if (m_req && m_addr_ok) begin
      w_lock_nxt = LK_FREE;
    end
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_id  = ARB_ID_INST;
    if (r_lock_st == LK_HELD) begin
      w_grant_vld = 1'b1;
      w_grant_id  = r_lock_id;
    end else if (d_req && i_req) begin
      w_grant_vld = 1'b1;
      w_grant_id  = (r_starve_cnt == SW'(STARVE_LIMIT)) ? ARB_ID_INST : ARB_ID_DATA;
    end else if (d_req) begin
      w_grant_vld = 1'b1;
      w_grant_id  = ARB_ID_DATA;
    end else if (i_req) begin
      w_grant_vld = 1'b1;
      w_grant_id  = ARB_ID_INST;
    end
    w_sel     = (w_grant_id == ARB_ID_DATA) ? w_d_fields : w_i_fields;
    m_req     = w_grant_vld & ((w_grant_id == ARB_ID_DATA) ? d_req : i_req) & ~w_full;
    m_wr      = w_sel.wr;
    m_size    = w_sel.size;
    m_addr    = w_sel.addr;
    m_wstrb   = w_sel.wstrb;
    m_wdata   = w_sel.wdata;
    w_hs      = m_req & m_addr_ok;
    i_addr_ok = w_hs & (w_grant_id == ARB_ID_INST);
    d_addr_ok = w_hs & (w_grant_id == ARB_ID_DATA);
  end

  // Data may win STARVE_LIMIT handshakes in a row while inst waits, then inst is forced.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_starve_cnt <= '0;
    end else if (!i_req || i_addr_ok) begin
      r_starve_cnt <= '0;
    end else if (d_addr_ok && (r_starve_cnt != SW'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_proto_err <= 1'b0;
    else if (m_data_ok && w_empty) r_proto_err <= 1'b1;
  end

  arb_id_fifo #(.DEPTH(MAX_OUTST), .CW(CNT_W)) u_id_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (w_hs),
    .i_id    (w_grant_id),
    .i_pop   (m_data_ok),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head),
    .o_count (outst_cnt)
  );

  assign w_pop     = m_data_ok & ~w_empty;
  assign i_data_ok = w_pop & (w_head == ARB_ID_INST);
  assign d_data_ok = w_pop & (w_head == ARB_ID_DATA);
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;
  assign proto_err = r_proto_err;
endmodule
